// File: rtl/ntt_pair_gather.sv
// Two-bank input reorder buffer: collects 4-beat groups of natural-order coefficient
// pairs and emits them as butterfly operand pairs. Optional sticky err port: NTT_GATHER_ERR_EN.
module ntt_pair_gather #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [ADDR_WIDTH-1:0] in0_addr,
  input  logic [ADDR_WIDTH-1:0] in1_addr,
  input  logic                  in0_en,
  input  logic                  in1_en,
  input  logic                  mode,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic [ADDR_WIDTH-1:0] out0_addr,
  output logic [ADDR_WIDTH-1:0] out1_addr,
  output logic                  out0_en,
  output logic                  out1_en
`ifdef NTT_GATHER_ERR_EN
  ,
  output logic                  err
`endif
);

  logic [DATA_WIDTH-1:0] r_data [2][8];
  logic [ADDR_WIDTH-1:0] r_addr [2][8];
  logic                  r_en   [2][8];
  logic [1:0]            r_mode;
  logic [1:0]            r_full;
  logic                  r_wb;
  logic                  r_rb;
  logic [1:0]            r_wbeat;
  logic [1:0]            r_rbeat;

  logic       w_wr_fire;
  logic       w_rd_fire;
  logic       w_close;
  logic [2:0] w_fill;
  logic [3:0] w_pad_from;
  logic [2:0] w_sel0;
  logic [2:0] w_sel1;

  assign in_ready  = ~r_full[r_wb];
  assign out_valid = r_full[r_rb];
  assign w_wr_fire = in_valid & in_ready;
  assign w_rd_fire = out_valid & out_ready;

  // A bank closes on its fourth beat, or on flush once it holds at least one beat.
  assign w_fill     = {1'b0, r_wbeat} + {2'b00, w_wr_fire};
  assign w_pad_from = {w_fill, 1'b0};
  assign w_close    = (w_wr_fire & ((r_wbeat == 2'd3) | flush)) |
                      (~w_wr_fire & flush & (r_wbeat != 2'd0));

  // Pointer, beat counter and full-flag bookkeeping for both sides.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_wbeat <= 2'd0;
      r_rbeat <= 2'd0;
      r_full  <= 2'b00;
    end else begin
      if (w_rd_fire) begin
        if (r_rbeat == 2'd3) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= ~r_rb;
          r_rbeat      <= 2'd0;
        end else begin
          r_rbeat <= r_rbeat + 2'd1;
        end
      end
      if (w_close) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
        r_wbeat      <= 2'd0;
      end else if (w_wr_fire) begin
        r_wbeat <= r_wbeat + 2'd1;
      end
    end
  end

  // Entry storage and per-bank mode; deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_fire && (r_wbeat == 2'd0)) begin
      r_mode[r_wb] <= mode;
    end
    for (int j = 0; j < 8; j++) begin
      if (w_wr_fire && (3'(j) >> 1) == {1'b0, r_wbeat}) begin
        r_data[r_wb][j] <= j[0] ? in1_data : in0_data;
        r_addr[r_wb][j] <= j[0] ? in1_addr : in0_addr;
        r_en[r_wb][j]   <= j[0] ? in1_en   : in0_en;
      end else if (w_close && (4'(j) >= w_pad_from)) begin
        r_en[r_wb][j] <= 1'b0;
      end
    end
  end

  // Stride-4 regroup pairs entry k with k+4; pass-through pairs 2k with 2k+1.
  always_comb begin
    w_sel0 = {r_rbeat, 1'b0};
    w_sel1 = {r_rbeat, 1'b1};
    if (r_mode[r_rb]) begin
      w_sel0 = {1'b0, r_rbeat};
      w_sel1 = {1'b1, r_rbeat};
    end
    out0_data = r_data[r_rb][w_sel0];
    out1_data = r_data[r_rb][w_sel1];
    out0_addr = r_addr[r_rb][w_sel0];
    out1_addr = r_addr[r_rb][w_sel1];
    out0_en   = out_valid & r_en[r_rb][w_sel0];
    out1_en   = out_valid & r_en[r_rb][w_sel1];
  end

`ifdef NTT_GATHER_ERR_EN
  logic r_err;

  // Sticky flag for upstream pushing into a stalled buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err = r_err;
`endif

endmodule
